// File: rtl/sha256_result_chk.sv
// Captures SHA-256 digests, counts leading zero bits against a difficulty target, exposes results over Avalon-MM.
// Optional build macro HASH_CNT_EN adds a 32-bit accepted-digest counter at word address 12.
module sha256_result_chk #(
    parameter int unsigned NWORDS = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hash_done,
    input  logic [NWORDS*32-1:0]     hash_in,
    input  logic [31:0]              nonce_in,
    input  logic                     chipselect,
    input  logic                     read,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        address,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    output logic                     found
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LZ_W   = 9;
    localparam int unsigned TGT_W  = 8;
    localparam int unsigned IDX_W  = $clog2(NWORDS);

    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] ADDR_NONCE  = ADDR_W'(9);
    localparam logic [ADDR_W-1:0] ADDR_TARGET = ADDR_W'(10);
    localparam logic [ADDR_W-1:0] ADDR_ACK    = ADDR_W'(11);
    localparam logic [ADDR_W-1:0] ADDR_COUNT  = ADDR_W'(12);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [WORD_W-1:0]      r_digest [NWORDS];
    logic [WORD_W-1:0]      r_nonce;
    logic [TGT_W-1:0]       r_target;
    logic [LZ_W-1:0]        r_lz;
    logic                   r_zrun;
    logic [IDX_W-1:0]       r_widx;
    logic                   r_valid;
    logic                   r_found;
    logic                   r_overrun;
    logic [WORD_W-1:0]      r_readdata;
`ifdef HASH_CNT_EN
    logic [WORD_W-1:0]      r_hash_cnt;
`endif

    logic                   w_ack;
    logic                   w_tgt_wr;
    logic                   w_rd;
    logic                   w_capture;
    logic                   w_drop;
    logic [WORD_W-1:0]      w_cur_word;
    logic [LZ_W-1:0]        w_word_lz;
    logic [LZ_W-1:0]        w_lz_sum;
    logic [WORD_W-1:0]      w_status;
    logic [WORD_W-1:0]      w_rdata;
    logic [WORD_W-1:0]      w_hash_cnt;
    logic                   w_unused;

    // Leading-zero count of one word; an all-zero word counts 32.
    function automatic logic [5:0] clz32(input logic [WORD_W-1:0] w);
        logic [5:0] n;
        logic       seen;
        n    = 6'd0;
        seen = 1'b0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (w[i]) begin
                seen = 1'b1;
            end else if (!seen) begin
                n = n + 6'd1;
            end
        end
        return n;
    endfunction

    assign w_ack      = chipselect && write && (address == ADDR_ACK);
    assign w_tgt_wr   = chipselect && write && (address == ADDR_TARGET);
    assign w_rd       = chipselect && read;
    assign w_capture  = hash_done && ((r_state == S_IDLE) || ((r_state == S_DONE) && w_ack));
    assign w_drop     = hash_done && !w_capture;
    assign w_cur_word = r_digest[r_widx];
    assign w_word_lz  = r_zrun ? LZ_W'(clz32(w_cur_word)) : '0;
    assign w_lz_sum   = r_lz + w_word_lz;
    assign w_status   = {27'b0, r_overrun, r_found, (r_state == S_CMP), r_valid, 1'b0};
    assign w_unused   = ^writedata[WORD_W-1:TGT_W];

`ifdef HASH_CNT_EN
    assign w_hash_cnt = r_hash_cnt;
`else
    assign w_hash_cnt = '0;
`endif

    // Register-map read mux
    always_comb begin
        w_rdata = '0;
        if (address < ADDR_W'(NWORDS)) begin
            w_rdata = r_digest[address[IDX_W-1:0]];
        end else begin
            case (address)
                ADDR_STATUS: w_rdata = w_status;
                ADDR_NONCE:  w_rdata = r_nonce;
                ADDR_TARGET: w_rdata = {{(WORD_W-TGT_W){1'b0}}, r_target};
                ADDR_COUNT:  w_rdata = w_hash_cnt;
                default:     w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            for (int n = 0; n < NWORDS; n++) r_digest[n] <= '0;
            r_nonce    <= '0;
            r_target   <= '0;
            r_lz       <= '0;
            r_zrun     <= 1'b0;
            r_widx     <= '0;
            r_valid    <= 1'b0;
            r_found    <= 1'b0;
            r_overrun  <= 1'b0;
            r_readdata <= '0;
`ifdef HASH_CNT_EN
            r_hash_cnt <= '0;
`endif
        end else begin
            if (w_rd) r_readdata <= w_rdata;
            if (w_tgt_wr) r_target <= writedata[TGT_W-1:0];

            // A dropped digest wins over a same-cycle ack
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (w_ack) begin
                r_overrun <= 1'b0;
            end

`ifdef HASH_CNT_EN
            if (w_capture) r_hash_cnt <= r_hash_cnt + WORD_W'(1);
`endif

            case (r_state)
                S_IDLE: begin
                end
                S_CMP: begin
                    r_lz   <= w_lz_sum;
                    r_widx <= r_widx + IDX_W'(1);
                    if (w_cur_word != '0) r_zrun <= 1'b0;
                    if (r_widx == IDX_W'(NWORDS - 1)) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b1;
                        r_found <= (w_lz_sum >= {1'b0, r_target});
                    end
                end
                S_DONE: begin
                    if (w_ack) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_found <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // New digest capture overrides the state transition above
            if (w_capture) begin
                for (int n = 0; n < NWORDS; n++) begin
                    r_digest[n] <= hash_in[WORD_W*(NWORDS-n)-1 -: WORD_W];
                end
                r_nonce <= nonce_in;
                r_widx  <= '0;
                r_lz    <= '0;
                r_zrun  <= 1'b1;
                r_state <= S_CMP;
            end
        end
    end

    assign readdata = r_readdata;
    assign found    = r_found;

endmodule

// File: tb/tb_sha256_result_chk.sv
// Randomized self-checking bench for sha256_result_chk; honours HASH_CNT_EN for the counter check.
module tb_sha256_result_chk;

    logic         clk = 1'b0;
    logic         reset;
    logic         hash_done;
    logic [255:0] hash_in;
    logic [31:0]  nonce_in;
    logic         chipselect;
    logic         read;
    logic         write;
    logic [3:0]   address;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         found;

    int checks = 0;
    int errors = 0;

    sha256_result_chk #(.NWORDS(8), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .hash_done(hash_done), .hash_in(hash_in),
        .nonce_in(nonce_in), .chipselect(chipselect), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata), .found(found)
    );

    always #5 clk = ~clk;

    // Reference: leading zero bits of the whole 256-bit digest, scanned from the MSB.
    function automatic int ref_lz(input logic [255:0] h);
        int  n;
        bit  stop;
        n = 0;
        stop = 0;
        for (int i = 255; i >= 0; i--) begin
            if (!stop) begin
                if (h[i]) stop = 1;
                else n++;
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] ref_status(input bit ov, input bit fd, input bit bz, input bit vl);
        return {27'b0, ov, fd, bz, vl, 1'b0};
    endfunction

    function automatic logic [31:0] ref_word(input logic [255:0] h, input int idx);
        return h[255 - 32*idx -: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send_hash(input logic [255:0] h, input logic [31:0] n);
        hash_done = 1'b1; hash_in = h; nonce_in = n;
        tick();
        hash_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        for (int a = 0; a <= 12; a++) begin
            bus_read(4'(a), d);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL reset_read addr=%0d got=%h exp=0", a, d);
            end
        end
        checks++;
        if (found !== 1'b0) begin
            errors++;
            $display("FAIL reset_found got=%b exp=0", found);
        end
    endtask

    task automatic test_directed();
        logic [255:0] h;
        logic [31:0]  d;
        h = {32'h0000_0FFF, {224{1'b1}}};
        bus_write(4'd10, 32'd16);
        send_hash(h, 32'h1234);
        repeat (7) tick();
        bus_read(4'd8, d);
        checks++;
        if (d !== ref_status(0, 0, 1, 0)) begin
            errors++;
            $display("FAIL dir_status_cmp got=%h exp=%h", d, ref_status(0, 0, 1, 0));
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL dir_found_t9 got=%b exp=1", found);
        end
        bus_read(4'd8, d);
        checks++;
        if (d !== ref_status(0, 1, 0, 1)) begin
            errors++;
            $display("FAIL dir_status_done got=%h exp=%h", d, ref_status(0, 1, 0, 1));
        end
        bus_read(4'd0, d);
        checks++;
        if (d !== 32'h0000_0FFF) begin
            errors++;
            $display("FAIL dir_word0 got=%h exp=00000fff", d);
        end
        bus_read(4'd9, d);
        checks++;
        if (d !== 32'h1234) begin
            errors++;
            $display("FAIL dir_nonce got=%h exp=00001234", d);
        end
        bus_write(4'd11, 32'd0);
        bus_read(4'd8, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL dir_status_ack got=%h exp=0", d);
        end
        // Same digest against a target it cannot meet
        bus_write(4'd10, 32'd40);
        send_hash(h, 32'h5678);
        repeat (8) tick();
        bus_read(4'd8, d);
        checks++;
        if (d !== ref_status(0, 0, 0, 1) || found !== 1'b0) begin
            errors++;
            $display("FAIL dir_t40 status=%h found=%b exp=%h/0", d, found, ref_status(0, 0, 0, 1));
        end
        bus_write(4'd11, 32'd0);
        bus_read(4'd8, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL dir_t40_ack got=%h exp=0", d);
        end
    endtask

    task automatic test_overrun();
        logic [255:0] ha;
        logic [255:0] hb;
        logic [31:0]  d;
        ha = {32'h00FF_0000, {224{1'b1}}};
        hb = {32'hFFFF_FFFF, {224{1'b0}}};
        bus_write(4'd10, 32'd0);
        send_hash(ha, 32'hA);
        repeat (2) tick();
        send_hash(hb, 32'hB);
        repeat (5) tick();
        bus_read(4'd8, d);
        checks++;
        if (d !== ref_status(1, 1, 0, 1)) begin
            errors++;
            $display("FAIL ovr_status got=%h exp=%h", d, ref_status(1, 1, 0, 1));
        end
        bus_read(4'd0, d);
        checks++;
        if (d !== ref_word(ha, 0)) begin
            errors++;
            $display("FAIL ovr_word0 got=%h exp=%h", d, ref_word(ha, 0));
        end
        bus_read(4'd9, d);
        checks++;
        if (d !== 32'hA) begin
            errors++;
            $display("FAIL ovr_nonce got=%h exp=0000000a", d);
        end
        bus_write(4'd11, 32'd0);
        bus_read(4'd8, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL ovr_ack got=%h exp=0", d);
        end
        // Drop during CMP, then ack while still in CMP clears only overrun
        send_hash(ha, 32'hC);
        send_hash(hb, 32'hD);
        bus_write(4'd11, 32'd0);
        bus_read(4'd8, d);
        checks++;
        if (d !== ref_status(0, 0, 1, 0)) begin
            errors++;
            $display("FAIL ovr_ack_cmp got=%h exp=%h", d, ref_status(0, 0, 1, 0));
        end
        repeat (5) tick();
        bus_read(4'd8, d);
        checks++;
        if (d !== ref_status(0, 1, 0, 1)) begin
            errors++;
            $display("FAIL ovr_after_cmp_ack got=%h exp=%h", d, ref_status(0, 1, 0, 1));
        end
        bus_write(4'd11, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic [255:0] h2;
        logic [31:0]  d;
        bit           fexp;
        bus_write(4'd10, 32'd255);
        send_hash(256'd0, 32'h1);
        repeat (8) tick();
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL b2b_zero_found got=%b exp=1", found);
        end
        for (int k = 0; k < 8; k++) h2[32*k +: 32] = $urandom;
        fexp = (ref_lz(h2) >= 255);
        chipselect = 1'b1; write = 1'b1; address = 4'd11; writedata = 32'd0;
        hash_done = 1'b1; hash_in = h2; nonce_in = 32'h7;
        tick();
        chipselect = 1'b0; write = 1'b0; hash_done = 1'b0;
        bus_read(4'd8, d);
        checks++;
        if (d !== ref_status(0, 0, 1, 0)) begin
            errors++;
            $display("FAIL b2b_status_cmp got=%h exp=%h", d, ref_status(0, 0, 1, 0));
        end
        repeat (7) tick();
        bus_read(4'd8, d);
        checks++;
        if (d !== ref_status(0, fexp, 0, 1)) begin
            errors++;
            $display("FAIL b2b_status_done got=%h exp=%h", d, ref_status(0, fexp, 0, 1));
        end
        bus_read(4'd9, d);
        checks++;
        if (d !== 32'h7) begin
            errors++;
            $display("FAIL b2b_nonce got=%h exp=00000007", d);
        end
        bus_write(4'd11, 32'd0);
    endtask

    task automatic test_target_midcmp();
        logic [255:0] h;
        logic [31:0]  d;
        h = {32'h003F_FFFF, {224{1'b1}}};
        bus_write(4'd10, 32'd0);
        send_hash(h, 32'h2);
        repeat (2) tick();
        bus_write(4'd10, 32'd12);
        repeat (5) tick();
        checks++;
        if (found !== (ref_lz(h) >= 12)) begin
            errors++;
            $display("FAIL tgt_mid_found got=%b exp=%b", found, ref_lz(h) >= 12);
        end
        bus_write(4'd10, 32'd5);
        tick();
        checks++;
        if (found !== (ref_lz(h) >= 12)) begin
            errors++;
            $display("FAIL tgt_frozen got=%b exp=%b", found, ref_lz(h) >= 12);
        end
        bus_read(4'd10, d);
        checks++;
        if (d !== 32'd5) begin
            errors++;
            $display("FAIL tgt_readback got=%h exp=00000005", d);
        end
        bus_write(4'd11, 32'd0);
    endtask

    task automatic test_random();
        logic [255:0] h;
        logic [31:0]  d;
        logic [31:0]  nn;
        int           lz;
        int           tgt;
        int           idx;
        bit           fexp;
        for (int it = 0; it < 24; it++) begin
            for (int k = 0; k < 8; k++) h[32*k +: 32] = $urandom;
            lz = $urandom_range(0, 256);
            if (lz == 256) h = '0;
            else begin
                h = h >> lz;
                h[255 - lz] = 1'b1;
            end
            tgt  = (it == 0) ? 0 : $urandom_range(0, 255);
            nn   = $urandom;
            fexp = (ref_lz(h) >= tgt);
            bus_write(4'd10, 32'(tgt));
            send_hash(h, nn);
            repeat (8) tick();
            checks++;
            if (found !== fexp) begin
                errors++;
                $display("FAIL rnd_found it=%0d lz=%0d tgt=%0d got=%b exp=%b", it, lz, tgt, found, fexp);
            end
            bus_read(4'd8, d);
            checks++;
            if (d !== ref_status(0, fexp, 0, 1)) begin
                errors++;
                $display("FAIL rnd_status it=%0d got=%h exp=%h", it, d, ref_status(0, fexp, 0, 1));
            end
            idx = $urandom_range(0, 7);
            bus_read(4'(idx), d);
            checks++;
            if (d !== ref_word(h, idx)) begin
                errors++;
                $display("FAIL rnd_word it=%0d idx=%0d got=%h exp=%h", it, idx, d, ref_word(h, idx));
            end
            bus_read(4'd9, d);
            checks++;
            if (d !== nn) begin
                errors++;
                $display("FAIL rnd_nonce it=%0d got=%h exp=%h", it, d, nn);
            end
            bus_write(4'd11, $urandom);
        end
        bus_read(4'd14, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL unmapped_read got=%h exp=0", d);
        end
    endtask

    task automatic test_counter();
        logic [255:0] h;
        logic [31:0]  d;
        logic [31:0]  exp_cnt;
        int           accepted;
        h = {32'h0000_00FF, {224{1'b1}}};
        accepted = 0;
        do_reset();
        send_hash(h, 32'd1);
        accepted++;
        tick();
        send_hash(h, 32'd2);
        repeat (6) tick();
        bus_write(4'd11, 32'd0);
        for (int k = 0; k < 2; k++) begin
            send_hash(h, 32'(k + 3));
            accepted++;
            repeat (8) tick();
            bus_write(4'd11, 32'd0);
        end
`ifdef HASH_CNT_EN
        exp_cnt = 32'(accepted);
`else
        exp_cnt = 32'd0;
`endif
        bus_read(4'd12, d);
        checks++;
        if (d !== exp_cnt) begin
            errors++;
            $display("FAIL hash_count got=%0d exp=%0d", d, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bus_write(4'd10, 32'd3);
        send_hash({32'h1234_5678, {224{1'b1}}}, 32'h99);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_read(4'd8, d);
        checks++;
        if (d !== 32'd0 || found !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_status got=%h found=%b exp=0/0", d, found);
        end
        bus_read(4'd0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_word0 got=%h exp=0", d);
        end
        bus_read(4'd10, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_target got=%h exp=0", d);
        end
    endtask

    initial begin
        reset = 1'b1; hash_done = 1'b0; hash_in = '0; nonce_in = '0;
        chipselect = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        test_reset();
        test_directed();
        test_overrun();
        test_back_to_back();
        test_target_midcmp();
        test_random();
        test_counter();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
